// File: rtl/counter_sevenseg_pkg.sv
// Shared types and glyph table for the multi-digit counter and seven-segment scan driver.
package counter_sevenseg_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] BLANK_GLYPH = 7'b0000000;

    // Segment order {a,b,c,d,e,f,g}, active-high, indexed by digit value.
    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/counter_sevenseg_mux_decode.sv
// Combinational 4-bit value to seven-segment glyph, forced dark when blank_i is set.
// Zero latency; no flow control.
module sevenseg_decode
    import counter_sevenseg_pkg::*;
(
    input  digit_t     val_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? BLANK_GLYPH : GLYPH[val_i];

endmodule

// File: rtl/counter_sevenseg_mux.sv
// Up/down hex or BCD counter with time-multiplexed seven-segment driver; count/carry 1 cycle, seg/an 1 cycle behind count.
// No backpressure: scan free-runs. COUNTER_SEVENSEG_BLANK_EN enables leading-zero blanking.
module counter_sevenseg_mux
    import counter_sevenseg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DECIMAL  = 0,
    parameter int SCAN_DIV = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                carry,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam digit_t TERM_UP = (DECIMAL != 0) ? 4'd9 : 4'd15;
    localparam int     DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int     IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                carry_q, carry_d;
    logic [DIV_W-1:0]    div_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;

    digit_t              dig;
    logic                ripple;
    digit_t              sel_dig;
    logic                blank;
    logic [6:0]          seg_w;
    logic                div_last;
    logic                idx_last;

    // A digit steps only while every lower digit sits at its terminal value.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        ripple  = 1'b1;
        dig     = '0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig = count_q[4*i +: 4];
                if (ripple) begin
                    if (up) count_d[4*i +: 4] = (dig >= TERM_UP) ? 4'd0 : dig + 4'd1;
                    else    count_d[4*i +: 4] = (dig == 4'd0) ? TERM_UP : dig - 4'd1;
                end
                ripple = ripple & (up ? (dig >= TERM_UP) : (dig == 4'd0));
            end
            carry_d = ripple;
        end
    end

    always_comb begin
        sel_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) sel_dig = count_q[4*i +: 4];
        end
    end

`ifdef COUNTER_SEVENSEG_BLANK_EN
    logic hi_zero;

    // Digit 0 is excluded from the walk so it always shows a glyph.
    always_comb begin
        blank   = 1'b0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero = hi_zero & (count_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) blank = hi_zero;
        end
    end
`else
    assign blank = 1'b0;
`endif

    sevenseg_decode u_decode (
        .val_i   (sel_dig),
        .blank_i (blank),
        .seg_o   (seg_w)
    );

    assign div_last = (div_q == DIV_W'(SCAN_DIV - 1));
    assign idx_last = (idx_q == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            carry_q <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            an_q    <= DIGITS'(1);
            seg_q   <= GLYPH[0];
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            div_q   <= div_last ? '0 : div_q + DIV_W'(1);
            if (div_last) idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
            an_q    <= DIGITS'(1) << idx_q;
            seg_q   <= seg_w;
        end
    end

    assign count = count_q;
    assign carry = carry_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: doc/counter_sevenseg_mux.md
# counter_sevenseg_mux

Parametrised multi-digit up/down counter with a time-multiplexed seven-segment display driver. Each digit runs in either hex or decimal (BCD) mode. The block supports synchronous load, enable, direction control and a wrap pulse for cascading. A single shared segment bus is driven together with a one-hot digit-select. The block sits between the user-facing control logic and the physical display pins.

## Interface
- DIGITS, 4: number of 4-bit digits; minimum 1.
- DECIMAL, 0: 0 = each digit counts 0..F; 1 = each digit counts 0..9 (BCD).
- SCAN_DIV, 1024: clock cycles each digit is shown; minimum 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable.
- up  in  1  1 = increment, 0 = decrement.
- load  in  1  synchronous load of load_val; has priority over en.
- load_val  in  4*DIGITS  value to load; digit 0 is in bits [3:0].
- count  out  4*DIGITS  current count, registered.
- carry  out  1  one-cycle pulse when the full count wraps.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-high, registered.
- an  out  DIGITS  one-hot digit select, active-high, registered.

## Operation
- Reset values: count=0, carry=0, scan index=0, divider=0, an=1 (digit 0), seg=7'b1111110 (the glyph for 0).
- Each rising edge is resolved in this priority order:
  - load=1: count<=load_val and carry<=0, regardless of en or up.
  - else en=1: count steps by ±1.
  - else: count holds and carry<=0.
- Ripple rule: digit i steps only when every lower digit is at its terminal value.
  - Terminal value when counting up: 9 (DECIMAL=1) or F.
  - Terminal value when counting down: 0.
- Up step: a digit at or above its terminal value goes to 0. Decimal digits loaded with A..F therefore wrap to 0 on their next step and carry on.
- Down step: a digit at 0 goes to 9 (DECIMAL=1) or F.
- carry<=1 exactly when every digit wraps in one step:
  - up: all digits at terminal, e.g. 9999 to 0000;
  - down: all digits 0, e.g. 0000 to 9999 or FFFF.
- Scan: the divider counts 0..SCAN_DIV-1. On the cycle it is at SCAN_DIV-1 it returns to 0 and the scan index advances, wrapping from DIGITS-1 to 0.
- Segment glyphs, value to seg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001;
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000;
  - 8=1111111, 9=1111011, A=1110111, b=0011111;
  - C=1001110, d=0111101, E=1001111, F=1000111.

## Timing
- count and carry update on the same edge that samples load/en. carry is high for exactly one cycle per wrap.
- seg and an are registered from the current scan index and count, so seg lags a count change by 1 cycle.
- After reset, digit 0 is selected for SCAN_DIV cycles, then digit 1, and so on. Each digit is selected for exactly SCAN_DIV cycles; with SCAN_DIV=1 the selection advances every cycle.
- load and en are independent of the scan; the scan never stalls.
- Reset assertion mid-operation forces all reset values immediately, with no clock needed. The first count step after deassertion starts from 0.

## Configuration
- COUNTER_SEVENSEG_BLANK_EN defined: leading-zero blanking.
  - A digit outputs seg=0000000 when it and every higher digit are 0.
  - Digit 0 is never blanked.
  - an still selects the blanked digit.
- Undefined: every digit always shows its glyph.

## Structure
- The shared package counter_sevenseg_pkg holds:
  - the 16-entry glyph constant array;
  - the digit-value type (4-bit);
  - the blank-glyph constant.
- One sub-module, sevenseg_decode: combinational 4-bit value to 7-bit glyph, with a blank input. It is instantiated once, on the scan path.

## Test plan
- DIGITS=4, DECIMAL=1, en=1 and up=1 for 12 cycles after reset: count=16'h0012 and carry is never asserted.
- DECIMAL=1: load 16'h9999, then one en up-step: count=16'h0000, carry=1 for 1 cycle. Then one down-step: count=16'h9999, carry=1.
- DECIMAL=0: load 16'hABCF, up-step gives 16'hABD0. load=1 together with en=1 and load_val=16'h0007 gives 16'h0007 (load wins).
- SCAN_DIV=4, count=16'h1234:
  - an=0001, seg=0110011 for 4 cycles;
  - then an=0010, seg=1111001;
  - then an=0100, seg=1101101;
  - then an=1000, seg=0110000;
  - then back to an=0001.
- Assert rst_n=0 mid-count at 16'h0456: count=0, carry=0, an=0001 and seg=1111110 take effect asynchronously.
- With COUNTER_SEVENSEG_BLANK_EN, count=16'h0005: digits 3..1 give seg=0000000 and digit 0 gives seg=1011011. Without the macro, digits 3..1 give seg=1111110.
